// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
// Covers the memory-stage FSM, exception codes, writeback select and MEM/WB payload.
package mips_pipe_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_BUSERR   = 2'd2;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2
  } wb_sel_e;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  exc;
  } memwb_t;

  // Link value outranks load data, which outranks the ALU result.
  function automatic wb_sel_e wb_select(input logic use_link, input logic mem_to_reg);
    if (use_link)        return WB_SEL_LINK;
    else if (mem_to_reg) return WB_SEL_MEM;
    else                 return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/mem_stage_wb_pipe_reg.sv
// MEM/WB pipeline register: a bubble is loaded on flush or while the stage stalls.
module wb_pipe_reg
  import mips_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clr,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  memwb_t q_d;
  memwb_t q_q;

  always_comb begin
    q_d = d;
    if (clr || bubble) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: req/ack data-memory access with timeout, writeback
// select, MEM/WB register and forwarding outputs for the hazard unit.
module mem_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned TMO_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        valid_i,
  input  logic        reg_wr_i,
  input  logic        mem_to_reg_i,
  input  logic        mem_wr_i,
  input  logic        use_link_reg_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] res_alu_i,
  input  logic [31:0] r_data_p2_i,
  input  logic [31:0] next_seq_pc_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic        fwd_reg_wr_o,
  output logic [4:0]  fwd_rd_o,
  output logic [31:0] fwd_data_o,
  output logic        fwd_is_load_o,
  output logic        valid_wb_o,
  output logic        reg_wr_wb_o,
  output logic [4:0]  rd_wb_o,
  output logic [31:0] wb_data_o,
  output logic [1:0]  exc_wb_o
);

  mem_state_e       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic        access;
  logic        misalign;
  logic        in_wait;
  logic        req_raw;
  logic        timeout_hit;
  logic        stall_raw;
  logic [31:0] wb_data;
  memwb_t      memwb_d;
  memwb_t      memwb_q;

  always_comb begin
    access      = valid_i & (mem_to_reg_i | mem_wr_i);
    misalign    = access & (res_alu_i[1:0] != 2'b00);
    in_wait     = (state_q == MEM_WAIT);
    req_raw     = in_wait | (access & ~misalign);
    // An ack arriving on the final count still wins over the timeout.
    timeout_hit = in_wait & (cnt_q == TMO_W'(TIMEOUT_CYCLES)) & ~dmem_ack;
    stall_raw   = req_raw & ~dmem_ack & ~timeout_hit;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (req_raw && !dmem_ack) begin
          state_d = MEM_WAIT;
          cnt_d   = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack || timeout_hit) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    unique case (wb_select(use_link_reg_i, mem_to_reg_i))
      WB_SEL_LINK: wb_data = next_seq_pc_i;
      WB_SEL_MEM:  wb_data = dmem_rdata;
      default:     wb_data = res_alu_i;
    endcase
  end

  always_comb begin
    memwb_d.valid  = valid_i;
    memwb_d.reg_wr = reg_wr_i & ~misalign & ~timeout_hit;
    memwb_d.rd     = rd_i;
    memwb_d.data   = wb_data;
    if (misalign) begin
      memwb_d.exc = EXC_MISALIGN;
    end else if (timeout_hit) begin
      memwb_d.exc = EXC_BUSERR;
    end else begin
      memwb_d.exc = EXC_NONE;
    end
  end

  wb_pipe_reg u_wb_pipe_reg (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .bubble (stall_raw),
    .d      (memwb_d),
    .q      (memwb_q)
  );

  // Request and stall are withdrawn at once while reset is held, even mid-access.
  assign dmem_req   = reset & req_raw;
  assign stall_o    = reset & stall_raw;
  assign dmem_we    = mem_wr_i;
  assign dmem_addr  = {res_alu_i[31:2], 2'b00};
  assign dmem_wdata = r_data_p2_i;

  assign fwd_reg_wr_o  = valid_i & reg_wr_i;
  assign fwd_rd_o      = rd_i;
  assign fwd_data_o    = use_link_reg_i ? next_seq_pc_i : res_alu_i;
  assign fwd_is_load_o = valid_i & mem_to_reg_i;

  assign valid_wb_o  = memwb_q.valid;
  assign reg_wr_wb_o = memwb_q.reg_wr;
  assign rd_wb_o     = memwb_q.rd;
  assign wb_data_o   = memwb_q.data;
  assign exc_wb_o    = memwb_q.exc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed expectations checked by immediate assertions.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        valid_i, reg_wr_i, mem_to_reg_i, mem_wr_i, use_link_reg_i;
  logic [4:0]  rd_i;
  logic [31:0] res_alu_i, r_data_p2_i, next_seq_pc_i;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_o;
  logic        fwd_reg_wr_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
  logic        fwd_is_load_o;
  logic        valid_wb_o, reg_wr_wb_o;
  logic [4:0]  rd_wb_o;
  logic [31:0] wb_data_o;
  logic [1:0]  exc_wb_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(16), .TMO_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .clr           (clr),
    .valid_i       (valid_i),
    .reg_wr_i      (reg_wr_i),
    .mem_to_reg_i  (mem_to_reg_i),
    .mem_wr_i      (mem_wr_i),
    .use_link_reg_i(use_link_reg_i),
    .rd_i          (rd_i),
    .res_alu_i     (res_alu_i),
    .r_data_p2_i   (r_data_p2_i),
    .next_seq_pc_i (next_seq_pc_i),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .stall_o       (stall_o),
    .fwd_reg_wr_o  (fwd_reg_wr_o),
    .fwd_rd_o      (fwd_rd_o),
    .fwd_data_o    (fwd_data_o),
    .fwd_is_load_o (fwd_is_load_o),
    .valid_wb_o    (valid_wb_o),
    .reg_wr_wb_o   (reg_wr_wb_o),
    .rd_wb_o       (rd_wb_o),
    .wb_data_o     (wb_data_o),
    .exc_wb_o      (exc_wb_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic rw, input logic m2r, input logic mw,
                        input logic lnk, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] pc);
    valid_i = v; reg_wr_i = rw; mem_to_reg_i = m2r; mem_wr_i = mw; use_link_reg_i = lnk;
    rd_i = rd; res_alu_i = alu; r_data_p2_i = wd; next_seq_pc_i = pc;
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                        input logic [31:0] data, input logic [1:0] exc);
    chk({tag, ".valid_wb"}, 32'(valid_wb_o), 32'(v));
    chk({tag, ".reg_wr_wb"}, 32'(reg_wr_wb_o), 32'(rw));
    chk({tag, ".rd_wb"}, 32'(rd_wb_o), 32'(rd));
    chk({tag, ".wb_data"}, wb_data_o, data);
    chk({tag, ".exc_wb"}, 32'(exc_wb_o), 32'(exc));
  endtask

  // Expect n consecutive stalled cycles with the request held and bubbles in MEM/WB.
  task automatic expect_stall(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".stall"}, 32'(stall_o), 32'd1);
      chk({tag, ".req"}, 32'(dmem_req), 32'd1);
      tick();
      chk({tag, ".bubble"}, 32'(valid_wb_o), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    set_op(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    #3;
    chk_wb("reset", 0, 0, 5'd0, 32'h0, 2'd0);
    chk("reset.req", 32'(dmem_req), 32'd0);
    chk("reset.stall", 32'(stall_o), 32'd0);
    tick(); tick();
    reset = 1'b1;

    // Zero-wait load
    set_op(1, 1, 1, 0, 0, 5'd5, 32'h100, 32'h0, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("lw0.req", 32'(dmem_req), 32'd1);
    chk("lw0.we", 32'(dmem_we), 32'd0);
    chk("lw0.addr", dmem_addr, 32'h100);
    chk("lw0.stall", 32'(stall_o), 32'd0);
    chk("lw0.fwd_is_load", 32'(fwd_is_load_o), 32'd1);
    chk("lw0.fwd_reg_wr", 32'(fwd_reg_wr_o), 32'd1);
    chk("lw0.fwd_rd", 32'(fwd_rd_o), 32'd5);
    tick();
    chk_wb("lw0", 1, 1, 5'd5, 32'hDEADBEEF, 2'd0);

    // Store with three wait cycles
    set_op(1, 0, 0, 1, 0, 5'd0, 32'h204, 32'h12345678, 32'h0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw3.we", 32'(dmem_we), 32'd1);
      chk("sw3.addr", dmem_addr, 32'h204);
      chk("sw3.wdata", dmem_wdata, 32'h12345678);
      expect_stall("sw3", 1);
    end
    dmem_ack = 1'b1;
    #1;
    chk("sw3.ack_req", 32'(dmem_req), 32'd1);
    chk("sw3.ack_stall", 32'(stall_o), 32'd0);
    tick();
    chk_wb("sw3", 1, 0, 5'd0, 32'h204, 2'd0);
    set_op(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmem_ack = 1'b0;
    #1;
    chk("sw3.idle_req", 32'(dmem_req), 32'd0);

    // Timeout on a load that never gets an ack
    set_op(1, 1, 1, 0, 0, 5'd7, 32'h300, 32'h0, 32'h0);
    #1;
    expect_stall("tmo", 16);
    chk("tmo.stall_end", 32'(stall_o), 32'd0);
    tick();
    chk_wb("tmo", 1, 0, 5'd7, 32'h0, 2'd2);
    set_op(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("tmo.req_drop", 32'(dmem_req), 32'd0);

    // Ack arriving on the timeout cycle completes normally
    set_op(1, 1, 1, 0, 0, 5'd8, 32'h308, 32'h0, 32'h0);
    #1;
    expect_stall("race", 16);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("race.stall", 32'(stall_o), 32'd0);
    tick();
    chk_wb("race", 1, 1, 5'd8, 32'hCAFEF00D, 2'd0);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;

    // Misaligned load
    set_op(1, 1, 1, 0, 0, 5'd3, 32'h102, 32'h0, 32'h0);
    #1;
    chk("mis.req", 32'(dmem_req), 32'd0);
    chk("mis.stall", 32'(stall_o), 32'd0);
    tick();
    chk_wb("mis", 1, 0, 5'd3, 32'h0, 2'd1);

    // jal link writeback
    set_op(1, 1, 0, 0, 1, 5'd31, 32'h1234, 32'h0, 32'h400008);
    #1;
    chk("jal.fwd_data", fwd_data_o, 32'h400008);
    chk("jal.fwd_is_load", 32'(fwd_is_load_o), 32'd0);
    chk("jal.req", 32'(dmem_req), 32'd0);
    tick();
    chk_wb("jal", 1, 1, 5'd31, 32'h400008, 2'd0);

    // clr turns a valid ALU op into a bubble
    set_op(1, 1, 0, 0, 0, 5'd9, 32'hA5A5, 32'h0, 32'h0);
    clr = 1'b1;
    #1;
    chk("clr.fwd_data", fwd_data_o, 32'hA5A5);
    tick();
    chk_wb("clr", 0, 0, 5'd0, 32'h0, 2'd0);
    clr = 1'b0;
    tick();
    chk_wb("alu", 1, 1, 5'd9, 32'hA5A5, 2'd0);

    // Asynchronous reset in the middle of a wait
    set_op(1, 1, 1, 0, 0, 5'd4, 32'h500, 32'h0, 32'h0);
    #1;
    expect_stall("rst", 3);
    #2;
    reset = 1'b0;
    #1;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk_wb("rst", 0, 0, 5'd0, 32'h0, 2'd0);
    tick();
    reset = 1'b1;
    #1;
    expect_stall("post_rst", 16);
    chk("post_rst.stall_end", 32'(stall_o), 32'd0);
    tick();
    chk_wb("post_rst", 1, 0, 5'd4, 32'h0, 2'd2);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    #1;
    chk("post_rst.lw_stall", 32'(stall_o), 32'd0);
    tick();
    chk_wb("post_rst.lw", 1, 1, 5'd4, 32'h0BADF00D, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
